// File: rtl/qcl_timeslice_arbiter.sv
// qcl_timeslice_arbiter: round-robin arbiter granting a shared resource in quantum-limited time slices
module qcl_timeslice_arbiter #(
    parameter int els_p = 4,
    parameter int width_p = 8,
    localparam int id_width_lp = $clog2(els_p)
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic [els_p-1:0]       reqs_i,
    input  logic                   yield_i,
    input  logic [width_p-1:0]     quantum_i,
    output logic [els_p-1:0]       grants_o,
    output logic [id_width_lp-1:0] owner_id_o,
    output logic                   busy_o,
    output logic [width_p-1:0]     slice_cnt_o,
    output logic                   expire_o
);
    typedef enum logic {IDLE, OWN} state_e;

    state_e                 state_q, state_d;
    logic [els_p-1:0]       grants_q, grants_d;
    logic [id_width_lp-1:0] owner_q, owner_d;
    logic [id_width_lp-1:0] last_q, last_d;
    logic [width_p-1:0]     cnt_q, cnt_d;
    logic [width_p-1:0]     quantum_q, quantum_d;
    logic [width_p-1:0]     cnt_inc;
    logic [id_width_lp-1:0] win, idx;
    logic                   found, expire, slice_end, arb;
    int                     n;

    // Find the first requester after last_q, wrapping modulo els_p
    always_comb begin
        found = 1'b0;
        win = '0;
        n = 0;
        idx = '0;
        for (int k = 1; k <= els_p; k++) begin
            n = int'(last_q) + k;
            n = (n >= els_p) ? n - els_p : n;
            idx = id_width_lp'(n);
            if (!found && reqs_i[idx]) begin
                found = 1'b1;
                win = idx;
            end
        end
    end

    // Slice bookkeeping and next-grant selection; a slice end re-arbitrates in the same cycle
    always_comb begin
        state_d = state_q;
        grants_d = grants_q;
        owner_d = owner_q;
        last_d = last_q;
        cnt_d = cnt_q;
        quantum_d = quantum_q;
        cnt_inc = cnt_q + 1'b1;
        expire = (state_q == OWN) && (cnt_inc == quantum_q);
        slice_end = (state_q == OWN) && (expire || yield_i || !reqs_i[owner_q]);
        arb = (state_q == IDLE) || slice_end;
        if (arb && found) begin
            state_d = OWN;
            grants_d = els_p'(1) << win;
            owner_d = win;
            last_d = win;
            cnt_d = '0;
            quantum_d = (quantum_i == '0) ? width_p'(1) : quantum_i;
        end else if (arb) begin
            state_d = IDLE;
            grants_d = '0;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_inc;
        end
    end

    // State registers; reset leaves requester 0 first in line
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            grants_q <= '0;
            owner_q <= '0;
            last_q <= id_width_lp'(els_p - 1);
            cnt_q <= '0;
            quantum_q <= width_p'(1);
        end else begin
            state_q <= state_d;
            grants_q <= grants_d;
            owner_q <= owner_d;
            last_q <= last_d;
            cnt_q <= cnt_d;
            quantum_q <= quantum_d;
        end
    end

    assign grants_o = grants_q;
    assign owner_id_o = owner_q;
    assign busy_o = (state_q == OWN);
    assign slice_cnt_o = cnt_q;
    assign expire_o = expire;
endmodule

// File: tb/tb_qcl_timeslice_arbiter.sv
// tb_qcl_timeslice_arbiter: randomized scoreboard bench against a behavioural slice model
module tb_qcl_timeslice_arbiter;
    logic       clk = 1'b0;
    logic       reset_i;
    logic [3:0] reqs_i;
    logic       yield_i;
    logic [7:0] quantum_i;
    logic [3:0] grants_o;
    logic [1:0] owner_id_o;
    logic       busy_o;
    logic [7:0] slice_cnt_o;
    logic       expire_o;

    typedef struct {
        logic [3:0] g;
        logic [1:0] id;
        logic       b;
        logic [7:0] c;
        logic       e;
    } exp_t;

    exp_t sbq[$];
    exp_t got_e;
    int   checks = 0;
    int   fails = 0;

    bit m_own;
    int m_owner, m_cnt, m_quant, m_last;

    qcl_timeslice_arbiter #(.els_p(4), .width_p(8)) dut (
        .clk_i(clk),
        .reset_i(reset_i),
        .reqs_i(reqs_i),
        .yield_i(yield_i),
        .quantum_i(quantum_i),
        .grants_o(grants_o),
        .owner_id_o(owner_id_o),
        .busy_o(busy_o),
        .slice_cnt_o(slice_cnt_o),
        .expire_o(expire_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h at %0t", nm, got, exp, $time);
        end
    endtask

    function automatic void grant(input logic [3:0] r, input logic [7:0] q);
        for (int k = 1; k <= 4; k++) begin
            int i;
            i = (m_last + k) % 4;
            if (r[i]) begin
                m_own = 1;
                m_owner = i;
                m_last = i;
                m_cnt = 0;
                m_quant = (q == 0) ? 1 : int'(q);
                return;
            end
        end
    endfunction

    function automatic void step(input logic rst, input logic [3:0] r, input logic y, input logic [7:0] q);
        bit ends;
        if (rst) begin
            m_own = 0;
            m_owner = 0;
            m_cnt = 0;
            m_last = 3;
        end else if (!m_own) begin
            if (r != 0) grant(r, q);
        end else begin
            ends = ((m_cnt + 1) % 256 == m_quant) || y || !r[m_owner];
            if (!ends) m_cnt = (m_cnt + 1) % 256;
            else if (r != 0) grant(r, q);
            else begin
                m_own = 0;
                m_cnt = 0;
            end
        end
    endfunction

    initial begin
        exp_t e;
        int ph;
        reset_i = 1'b1;
        reqs_i = '0;
        yield_i = 1'b0;
        quantum_i = '0;
        m_own = 0;
        m_owner = 0;
        m_cnt = 0;
        m_quant = 1;
        m_last = 3;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            @(posedge clk);
            #2;
            step(reset_i, reqs_i, yield_i, quantum_i);
            ph = (cyc / 200) % 5;
            reset_i = (cyc < 3) || (cyc % 200 == 199) || (ph >= 3 && $urandom % 60 == 0);
            case (ph)
                0: begin reqs_i = 4'hF; quantum_i = 8'd3; yield_i = 1'b0; end
                1: begin reqs_i = ($urandom % 30 == 0) ? 4'h0 : 4'b0100; quantum_i = 8'd2; yield_i = 1'b0; end
                2: begin
                    reqs_i = ($urandom % 8 == 0) ? 4'($urandom) : (reqs_i == 0 ? 4'b0011 : reqs_i);
                    quantum_i = 8'd0;
                    yield_i = 1'b0;
                end
                3: begin
                    reqs_i = ($urandom % 4 == 0) ? 4'($urandom) : reqs_i;
                    quantum_i = 8'($urandom_range(0, 6));
                    yield_i = ($urandom % 6 == 0);
                end
                default: begin
                    reqs_i = 4'($urandom);
                    quantum_i = ($urandom % 20 == 0) ? 8'd255 : 8'($urandom_range(0, 5));
                    yield_i = ($urandom % 10 == 0);
                end
            endcase
            e.g = m_own ? 4'(1 << m_owner) : 4'h0;
            e.id = 2'(m_owner);
            e.b = m_own;
            e.c = 8'(m_cnt);
            e.e = m_own && ((m_cnt + 1) % 256 == m_quant);
            sbq.push_back(e);
        end
        repeat (3) @(posedge clk);
        checks++;
        if (sbq.size() != 0) begin
            fails++;
            $display("FAIL drain got=%0d pending exp=0", sbq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

    always @(negedge clk) begin
        if (sbq.size() > 0) begin
            got_e = sbq.pop_front();
            chk("grants", 32'(grants_o), 32'(got_e.g));
            chk("owner_id", 32'(owner_id_o), 32'(got_e.id));
            chk("busy", 32'(busy_o), 32'(got_e.b));
            chk("slice_cnt", 32'(slice_cnt_o), 32'(got_e.c));
            chk("expire", 32'(expire_o), 32'(got_e.e));
        end
    end
endmodule
